// File: rtl/fpu_special_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fpu_special_pkg: operand classes, opcodes and special-value builders |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package fpu_special_pkg;

  typedef enum logic [2:0] {
    CLS_ZERO = 3'd0,
    CLS_SUB  = 3'd1,
    CLS_NORM = 3'd2,
    CLS_INF  = 3'd3,
    CLS_QNAN = 3'd4,
    CLS_SNAN = 3'd5
  } fp_class_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Builders return a 64-bit container; callers truncate to their width.
  function automatic logic [63:0] fp_exp_ones(input int w, input int ew);
    return ((64'd1 << ew) - 64'd1) << (w - 1 - ew);
  endfunction

  function automatic logic [63:0] fp_qnan(input int w, input int ew);
    return fp_exp_ones(w, ew) | (64'd1 << (w - 2 - ew));
  endfunction

  function automatic logic [63:0] fp_inf(input int w, input int ew, input logic s);
    return fp_exp_ones(w, ew) | ({63'd0, s} << (w - 1));
  endfunction

  function automatic logic [63:0] fp_zero(input int w, input logic s);
    return {63'd0, s} << (w - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_classify.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fp_classify: combinational IEEE-754 operand classifier               |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module fp_classify
  import fpu_special_pkg::*;
#(
  parameter int W  = 32,
  parameter int EW = 8
) (
  input  logic [W-1:0] op_i,
  output logic [2:0]   cls_o,
  output logic         sign_o
);

  localparam int MW = W - EW - 1;

  logic [EW-1:0] exp_f;
  logic [MW-1:0] frac_f;

  assign exp_f  = op_i[W-2 -: EW];
  assign frac_f = op_i[MW-1:0];
  assign sign_o = op_i[W-1];

  always_comb begin
    cls_o = CLS_NORM;
    if (exp_f == '0) begin
      cls_o = (frac_f == '0) ? CLS_ZERO : CLS_SUB;
    end else if (&exp_f) begin
      if (frac_f == '0)        cls_o = CLS_INF;
      else if (frac_f[MW-1])   cls_o = CLS_QNAN;
      else                     cls_o = CLS_SNAN;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpu_special_case_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fpu_special_case_unit: 2-stage special-operand bypass and IEEE flags |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module fpu_special_case_unit
  import fpu_special_pkg::*;
#(
  parameter int W  = 32,
  parameter int EW = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [1:0]   operation,
  input  logic [W-1:0] data1,
  input  logic [W-1:0] data2,
  input  logic         flag_clear,
  output logic         valid_o,
  output logic         special_o,
  output logic         nan_flag,
  output logic [W-1:0] result_o,
  output logic         invalid_sticky,
  output logic         divzero_sticky
);

  localparam logic [W-1:0] QNAN_C = W'(fp_qnan(W, EW));

  logic [2:0]   cls_a_d, cls_b_d;
  logic         sa_d, sb_d;

  logic         v1_q;
  logic [1:0]   op_q;
  logic [2:0]   cls_a_q, cls_b_q;
  logic         sa_q, sb_q;

  logic         special_d, nan_d, inv_d, dz_d;
  logic [W-1:0] result_d;

  logic         valid_q, special_q, nan_q, inv_q, dz_q;
  logic [W-1:0] result_q;

  fp_classify #(.W(W), .EW(EW)) u_cls_a (.op_i(data1), .cls_o(cls_a_d), .sign_o(sa_d));
  fp_classify #(.W(W), .EW(EW)) u_cls_b (.op_i(data2), .cls_o(cls_b_d), .sign_o(sb_d));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      op_q    <= OP_ADD;
      cls_a_q <= CLS_ZERO;
      cls_b_q <= CLS_ZERO;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
    end else begin
      v1_q <= valid_i;
      if (valid_i) begin
        op_q    <= operation;
        cls_a_q <= cls_a_d;
        cls_b_q <= cls_b_d;
        sa_q    <= sa_d;
        sb_q    <= sb_d;
      end
    end
  end

  logic a_zero, b_zero, a_inf, b_inf, a_fin, b_fin, any_snan, any_qnan;
  logic sx, sb_eff;

  assign a_zero   = (cls_a_q == CLS_ZERO);
  assign b_zero   = (cls_b_q == CLS_ZERO);
  assign a_inf    = (cls_a_q == CLS_INF);
  assign b_inf    = (cls_b_q == CLS_INF);
  assign a_fin    = (cls_a_q == CLS_SUB) || (cls_a_q == CLS_NORM);
  assign b_fin    = (cls_b_q == CLS_SUB) || (cls_b_q == CLS_NORM);
  assign any_snan = (cls_a_q == CLS_SNAN) || (cls_b_q == CLS_SNAN);
  assign any_qnan = (cls_a_q == CLS_QNAN) || (cls_b_q == CLS_QNAN);
  assign sx       = sa_q ^ sb_q;
  // Subtraction is addition of the negated second operand.
  assign sb_eff   = sb_q ^ (op_q == OP_SUB);

  always_comb begin
    special_d = 1'b0;
    nan_d     = 1'b0;
    inv_d     = 1'b0;
    dz_d      = 1'b0;
    result_d  = '0;
    if (any_snan) begin
      special_d = 1'b1;
      nan_d     = 1'b1;
      inv_d     = 1'b1;
      result_d  = QNAN_C;
    end else if (any_qnan) begin
      special_d = 1'b1;
      nan_d     = 1'b1;
      result_d  = QNAN_C;
    end else begin
      unique case (op_q)
        OP_ADD, OP_SUB: begin
          if (a_inf && b_inf && (sa_q != sb_eff)) begin
            special_d = 1'b1;
            nan_d     = 1'b1;
            inv_d     = 1'b1;
            result_d  = QNAN_C;
          end else if (a_inf) begin
            special_d = 1'b1;
            result_d  = W'(fp_inf(W, EW, sa_q));
          end else if (b_inf) begin
            special_d = 1'b1;
            result_d  = W'(fp_inf(W, EW, sb_eff));
          end
        end
        OP_MUL: begin
          if ((a_zero && b_inf) || (a_inf && b_zero)) begin
            special_d = 1'b1;
            nan_d     = 1'b1;
            inv_d     = 1'b1;
            result_d  = QNAN_C;
          end else if (a_inf || b_inf) begin
            special_d = 1'b1;
            result_d  = W'(fp_inf(W, EW, sx));
          end else if (a_zero || b_zero) begin
            special_d = 1'b1;
            result_d  = W'(fp_zero(W, sx));
          end
        end
        default: begin
          if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            special_d = 1'b1;
            nan_d     = 1'b1;
            inv_d     = 1'b1;
            result_d  = QNAN_C;
          end else if (a_fin && b_zero) begin
            special_d = 1'b1;
            dz_d      = 1'b1;
            result_d  = W'(fp_inf(W, EW, sx));
          end else if (a_inf) begin
            special_d = 1'b1;
            result_d  = W'(fp_inf(W, EW, sx));
          end else if (b_inf || (a_zero && b_fin)) begin
            special_d = 1'b1;
            result_d  = W'(fp_zero(W, sx));
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      special_q <= 1'b0;
      nan_q     <= 1'b0;
      result_q  <= '0;
      inv_q     <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      valid_q   <= v1_q;
      special_q <= v1_q & special_d;
      nan_q     <= v1_q & nan_d;
      result_q  <= v1_q ? result_d : '0;
      // A new set on the same edge as a clear wins.
      inv_q     <= (v1_q & inv_d) | (inv_q & ~flag_clear);
      dz_q      <= (v1_q & dz_d)  | (dz_q  & ~flag_clear);
    end
  end

  assign valid_o        = valid_q;
  assign special_o      = special_q;
  assign nan_flag       = nan_q;
  assign result_o       = result_q;
  assign invalid_sticky = inv_q;
  assign divzero_sticky = dz_q;

endmodule
`default_nettype wire

// File: doc/fpu_special_case_unit.md
# fpu_special_case_unit

Parametrised, pipelined special-operand handler for the FPU add/sub, mul and div datapaths. It classifies both operands and detects every IEEE-754 invalid case, not just infinity/zero combinations, including NaN inputs. It also produces the bypass result (canonical qNaN, signed infinity or signed zero) and keeps sticky invalid and divide-by-zero exception flags. It sits beside the arithmetic cores in the FPU interface. When `special_o` is set, the result mux selects `result_o` instead of the core output.

## Interface
- `W`, 32 — word width; 32 (single) or 64 (double) only.
- `EW`, 8 — exponent width; 8 for W=32, 11 for W=64. Mantissa width MW = W-EW-1.
- `clk` in 1 — clock, all state on rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `valid_i` in 1 — operands/opcode valid this cycle.
- `operation` in 2 — 00 add, 01 sub, 10 mul, 11 div.
- `data1` in W — operand A (divisor-side is data2).
- `data2` in W — operand B.
- `flag_clear` in 1 — clear sticky flags.
- `valid_o` out 1 — outputs below valid this cycle.
- `special_o` out 1 — result is a special case; bypass core.
- `nan_flag` out 1 — result is NaN.
- `result_o` out W — bypass result; all zeros when `special_o`=0.
- `invalid_sticky` out 1 — sticky IEEE invalid flag.
- `divzero_sticky` out 1 — sticky divide-by-zero flag.

## Operation
Operands are classified per field:
- exp=0, frac=0 → ZERO.
- exp=0, frac≠0 → SUB; treated as finite nonzero.
- exp all ones, frac=0 → INF.
- exp all ones, frac MSB=1 → QNAN.
- exp all ones, frac MSB=0, frac≠0 → SNAN.
- otherwise → NORM.

Decision rules, first match wins:
1. Any SNAN → canonical qNaN, invalid.
2. Any QNAN → canonical qNaN, no flag.
3. Add: INF with INF of opposite sign → qNaN, invalid. Sub: INF with INF of same sign → qNaN, invalid. Otherwise any INF → that INF; for sub, a data2 INF has its sign flipped.
4. Mul: ZERO×INF in either order → qNaN, invalid. Otherwise INF → INF with sign = s1^s2. ZERO×finite → zero with sign s1^s2.
5. Div:
   - ZERO/ZERO or INF/INF → qNaN, invalid.
   - finite-nonzero/ZERO → INF with sign s1^s2, divzero.
   - INF/finite → INF.
   - finite/INF or ZERO/finite-nonzero → zero.
   - All with sign s1^s2.
6. Else `special_o`=0 and `result_o`=0. Add/sub with ZERO operands is not special; the core handles it.

Canonical qNaN is sign 0, exp all ones, frac MSB 1, rest 0: 0x7FC00000 (W=32), 0x7FF8000000000000 (W=64).

`nan_flag` is 1 exactly when `result_o` is a qNaN.

## Timing
- Latency is 2 cycles, fully pipelined at one op per cycle, with no stall.
  - Stage 1 registers operand classes, signs and opcode.
  - Stage 2 registers the decision outputs.
- `valid_o` equals `valid_i` delayed by 2 cycles. When `valid_o`=0, all other outputs are 0 except the sticky flags.
- Sticky flags update on the same edge that `valid_o` rises for the flagged op. They stay set until `flag_clear`.
- `flag_clear` takes effect on the next edge. If clear and a new set land on the same edge, set wins and the flag reads 1.
- Reset values: all outputs 0, pipeline valid bits 0, sticky flags 0.
- Reset mid-operation flushes in-flight ops. No `valid_o` is produced for ops accepted before reset.
- Data and opcode are ignored when `valid_i`=0, and no flag may change.

## Structure
- Shared package `fpu_special_pkg` holds:
  - the operand class enum (ZERO, SUB, NORM, INF, QNAN, SNAN);
  - opcode constants;
  - the canonical-qNaN and signed-INF/zero constructor functions, parametrised by W/EW.
- Sub-module `fp_classify` is combinational, parameters W and EW: operand in, class and sign out. It is instantiated twice in stage 1.
- The top level holds the pipeline registers, the decision logic and the sticky flags.

## Test plan
- W=64, add, 0x7FF0000000000000 + 0xFFF0000000000000 → after 2 cycles: `special_o`=1, `nan_flag`=1, `result_o`=0x7FF8000000000000, `invalid_sticky`=1.
- W=32, div, 0x3F800000 / 0x80000000 → `result_o`=0xFF800000, `nan_flag`=0, `divzero_sticky`=1, `invalid_sticky` unchanged.
- W=64, mul with an SNAN operand (0x7FF0000000000001 × 0x3FF0000000000000) → canonical qNaN and invalid set. Repeat with QNAN 0x7FF8000000000001 → qNaN output, invalid not newly set.
- Back-to-back ops over 4 cycles (sub inf−inf, mul 2×3, div 0/0, add 1+1) → `valid_o` for 4 consecutive cycles starting cycle 2; `special_o` pattern 1,0,1,0.
- Assert `flag_clear` on the edge where a new invalid op retires → flag reads 1. Clear alone next cycle → 0.
- Assert `rst` while 2 ops are in flight → all outputs 0 immediately; no `valid_o` after release; sticky flags 0.
